// File: rtl/pipeline_stage_registers_pkg.sv
`default_nettype none
// ============================================================================
// Package : pipeline_stage_registers_pkg
// Brief   : IF_ID / ID_EX register layouts, ALU ops, RV32I opcodes.
// Rev     : 1.0
// ============================================================================
package pipeline_stage_registers_pkg;

  localparam int XLEN          = 32;
  localparam int PC_W          = 16;
  localparam int RA_W          = 5;
  localparam int DEFAULT_CNT_W = 16;

  localparam logic [6:0] c_op_lui      = 7'b0110111;
  localparam logic [6:0] c_op_auipc    = 7'b0010111;
  localparam logic [6:0] c_op_jal      = 7'b1101111;
  localparam logic [6:0] c_op_jalr     = 7'b1100111;
  localparam logic [6:0] c_op_branch   = 7'b1100011;
  localparam logic [6:0] c_op_load     = 7'b0000011;
  localparam logic [6:0] c_op_store    = 7'b0100011;
  localparam logic [6:0] c_op_op_imm   = 7'b0010011;
  localparam logic [6:0] c_op_op       = 7'b0110011;
  localparam logic [6:0] c_op_misc_mem = 7'b0001111;
  localparam logic [6:0] c_op_system   = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     fetched_inst;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic            do_not_execute;
  } if_id_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    alu_op_t         alu_op;
    logic [2:0]      funct3;
    logic            is_load;
    logic            is_store;
    logic            is_branch;
    logic            is_jump;
    logic            wb_en;
    logic            illegal;
    logic            do_not_execute;
  } id_ex_t;

  // alt selects SUB/SRA; for OP-IMM the caller only sets it for SRAI
  function automatic alu_op_t alu_from_funct3(input logic [2:0] funct3, input logic alt);
    alu_op_t op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
// Module : imm_gen
// Brief  : RV32I immediate extraction (I/S/B/U/J), sign-extended to XLEN.
// Rev    : 1.0
// ============================================================================
module imm_gen
  import pipeline_stage_registers_pkg::*;
(
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm
);

  logic [6:0] w_opcode;
  assign w_opcode = inst[6:0];

  always_comb begin
    imm = '0;
    case (w_opcode)
      c_op_op_imm, c_op_load, c_op_jalr:
        imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
      c_op_store:
        imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
      c_op_branch:
        imm = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      c_op_lui, c_op_auipc:
        imm = {inst[31:12], 12'b0};
      c_op_jal:
        imm = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/decode_unit.sv
`default_nettype none
// ============================================================================
// Module : decode_unit
// Brief  : RV32I ID stage: operand read/bypass, decode, load-use and
//          control-transfer hold-off FSM.
// Rev    : 1.0
// ============================================================================
module decode_unit
  import pipeline_stage_registers_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  if_id_t           if_id_r,
  output logic [RA_W-1:0]  rf_rd_addr1,
  output logic [RA_W-1:0]  rf_rd_addr2,
  input  logic [XLEN-1:0]  rf_rd_data1,
  input  logic [XLEN-1:0]  rf_rd_data2,
  input  logic             wb_we,
  input  logic [RA_W-1:0]  wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             redirect_valid,
  output logic             stall_fetch,
  output logic             jump_in_progress,
  output id_ex_t           id_ex_r,
  output logic [CNT_W-1:0] bubble_count
);

  typedef enum logic [0:0] {
    ST_RUN       = 1'b0,
    ST_CTRL_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_bubble_count;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  alu_op_t         w_alu_op;
  logic            w_is_load;
  logic            w_is_store;
  logic            w_is_branch;
  logic            w_is_jump;
  logic            w_writes_rd;
  logic            w_uses_rs1;
  logic            w_uses_rs2;
  logic            w_illegal;
  logic            w_load_use;
  logic            w_insert_bubble;
  id_ex_t          w_decoded;
  id_ex_t          w_bubble;

  assign rf_rd_addr1 = if_id_r.rs1;
  assign rf_rd_addr2 = if_id_r.rs2;
  assign w_opcode    = if_id_r.fetched_inst[6:0];
  assign w_funct3    = if_id_r.fetched_inst[14:12];

  imm_gen u_imm_gen (
    .inst (if_id_r.fetched_inst),
    .imm  (w_imm)
  );

  // x0 reads as zero even if writeback targets it
  always_comb begin
    w_rs1_val = rf_rd_data1;
    w_rs2_val = rf_rd_data2;
    if (if_id_r.rs1 == '0)
      w_rs1_val = '0;
    else if (wb_we && (wb_rd == if_id_r.rs1))
      w_rs1_val = wb_data;
    if (if_id_r.rs2 == '0)
      w_rs2_val = '0;
    else if (wb_we && (wb_rd == if_id_r.rs2))
      w_rs2_val = wb_data;
  end

  always_comb begin
    w_alu_op    = ALU_ADD;
    w_is_load   = 1'b0;
    w_is_store  = 1'b0;
    w_is_branch = 1'b0;
    w_is_jump   = 1'b0;
    w_writes_rd = 1'b0;
    w_uses_rs1  = 1'b0;
    w_uses_rs2  = 1'b0;
    w_illegal   = 1'b0;
    case (w_opcode)
      c_op_lui: begin
        w_alu_op    = ALU_LUI;
        w_writes_rd = 1'b1;
      end
      c_op_auipc: w_writes_rd = 1'b1;
      c_op_jal: begin
        w_is_jump   = 1'b1;
        w_writes_rd = 1'b1;
      end
      c_op_jalr: begin
        w_is_jump   = 1'b1;
        w_writes_rd = 1'b1;
        w_uses_rs1  = 1'b1;
      end
      c_op_branch: begin
        w_is_branch = 1'b1;
        w_alu_op    = ALU_SUB;
        w_uses_rs1  = 1'b1;
        w_uses_rs2  = 1'b1;
      end
      c_op_load: begin
        w_is_load   = 1'b1;
        w_writes_rd = 1'b1;
        w_uses_rs1  = 1'b1;
      end
      c_op_store: begin
        w_is_store = 1'b1;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      c_op_op_imm: begin
        w_alu_op    = alu_from_funct3(w_funct3,
                        (w_funct3 == 3'b101) && if_id_r.fetched_inst[30]);
        w_writes_rd = 1'b1;
        w_uses_rs1  = 1'b1;
      end
      c_op_op: begin
        w_alu_op    = alu_from_funct3(w_funct3, if_id_r.fetched_inst[30]);
        w_writes_rd = 1'b1;
        w_uses_rs1  = 1'b1;
        w_uses_rs2  = 1'b1;
      end
      c_op_misc_mem, c_op_system: ;
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_decoded                = '0;
    w_decoded.pc             = if_id_r.pc;
    w_decoded.rs1            = if_id_r.rs1;
    w_decoded.rs2            = if_id_r.rs2;
    w_decoded.rd             = if_id_r.rd;
    w_decoded.rs1_val        = w_rs1_val;
    w_decoded.rs2_val        = w_rs2_val;
    w_decoded.imm            = w_imm;
    w_decoded.alu_op         = w_alu_op;
    w_decoded.funct3         = w_funct3;
    w_decoded.is_load        = w_is_load;
    w_decoded.is_store       = w_is_store;
    w_decoded.is_branch      = w_is_branch;
    w_decoded.is_jump        = w_is_jump;
    w_decoded.wb_en          = w_writes_rd && (if_id_r.rd != '0);
    w_decoded.illegal        = w_illegal;
    w_decoded.do_not_execute = 1'b0;

    w_bubble                 = '0;
    w_bubble.pc              = if_id_r.pc;
    w_bubble.do_not_execute  = 1'b1;
  end

  assign w_load_use = !id_ex_r.do_not_execute && id_ex_r.is_load && (id_ex_r.rd != '0) &&
                      ((w_uses_rs1 && (if_id_r.rs1 == id_ex_r.rd)) ||
                       (w_uses_rs2 && (if_id_r.rs2 == id_ex_r.rd)));

  // Redirect flushes ID and wins over both the load-use stall and control entry
  always_comb begin
    w_state_next    = r_state;
    w_insert_bubble = 1'b1;
    stall_fetch     = 1'b0;
    if (redirect_valid) begin
      w_state_next = ST_RUN;
    end else if (r_state == ST_RUN) begin
      if (if_id_r.do_not_execute) begin
        w_state_next = ST_RUN;
      end else if (w_load_use) begin
        stall_fetch = 1'b1;
      end else begin
        w_insert_bubble = 1'b0;
        if (w_is_branch || w_is_jump)
          w_state_next = ST_CTRL_WAIT;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state                <= ST_RUN;
      id_ex_r                <= '0;
      id_ex_r.do_not_execute <= 1'b1;
      r_bubble_count         <= '0;
    end else begin
      r_state <= w_state_next;
      id_ex_r <= w_insert_bubble ? w_bubble : w_decoded;
      if (w_insert_bubble && (r_bubble_count != '1))
        r_bubble_count <= r_bubble_count + c_cnt_one;
    end
  end

  assign jump_in_progress = (r_state == ST_CTRL_WAIT);
  assign bubble_count     = r_bubble_count;

endmodule
`default_nettype wire

// File: tb/tb_decode_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_decode_unit
// Brief  : Self-checking bench for decode_unit (vector table + scoreboard).
// Rev    : 1.0
// ============================================================================
module tb_decode_unit;
  import pipeline_stage_registers_pkg::*;

  localparam int TB_CNT_W = 4;

  logic                clk = 1'b0;
  logic                reset;
  if_id_t              if_id;
  logic [RA_W-1:0]     rf_rd_addr1, rf_rd_addr2;
  logic [XLEN-1:0]     rf1, rf2;
  logic                wb_we;
  logic [RA_W-1:0]     wb_rd;
  logic [XLEN-1:0]     wb_data;
  logic                redirect_valid;
  logic                stall_fetch;
  logic                jump_in_progress;
  id_ex_t              id_ex_r;
  logic [TB_CNT_W-1:0] bubble_count;

  int n_checks = 0;
  int n_errors = 0;

  decode_unit #(.CNT_W(TB_CNT_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .if_id_r          (if_id),
    .rf_rd_addr1      (rf_rd_addr1),
    .rf_rd_addr2      (rf_rd_addr2),
    .rf_rd_data1      (rf1),
    .rf_rd_data2      (rf2),
    .wb_we            (wb_we),
    .wb_rd            (wb_rd),
    .wb_data          (wb_data),
    .redirect_valid   (redirect_valid),
    .stall_fetch      (stall_fetch),
    .jump_in_progress (jump_in_progress),
    .id_ex_r          (id_ex_r),
    .bubble_count     (bubble_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        dne;
    logic [15:0] pc;
    logic [4:0]  rd;
    logic [31:0] rs1_val, rs2_val, imm;
    logic [3:0]  alu;
    logic        wb_en, is_load, is_store, is_ctrl, illegal;
  } exp_t;

  typedef struct {
    string       tag;
    logic [31:0] inst;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rf1, rf2;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] e_rs1, e_rs2, e_imm;
    alu_op_t     e_alu;
    logic        e_wb, e_ld, e_st, e_ill;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[10];

  task automatic chk(input string what, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", what, got, want);
    end
  endtask

  function automatic exp_t mk_dec(input string tag, input logic [15:0] pc, input logic [4:0] rd,
                                  input logic [31:0] r1, r2, imm, input alu_op_t alu,
                                  input logic wb, ld, st, ctrl, ill);
    exp_t e;
    e.tag = tag; e.dne = 1'b0; e.pc = pc; e.rd = rd;
    e.rs1_val = r1; e.rs2_val = r2; e.imm = imm; e.alu = alu;
    e.wb_en = wb; e.is_load = ld; e.is_store = st; e.is_ctrl = ctrl; e.illegal = ill;
    return e;
  endfunction

  function automatic exp_t mk_bub(input string tag, input logic [15:0] pc);
    exp_t e;
    e = mk_dec(tag, pc, 5'd0, 32'd0, 32'd0, 32'd0, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e.dne = 1'b1;
    return e;
  endfunction

  task automatic check_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = sb_q.pop_front();
    chk({e.tag, " dne"},     32'(id_ex_r.do_not_execute), 32'(e.dne));
    chk({e.tag, " pc"},      32'(id_ex_r.pc),             32'(e.pc));
    chk({e.tag, " rd"},      32'(id_ex_r.rd),             32'(e.rd));
    chk({e.tag, " rs1_val"}, id_ex_r.rs1_val,             e.rs1_val);
    chk({e.tag, " rs2_val"}, id_ex_r.rs2_val,             e.rs2_val);
    chk({e.tag, " imm"},     id_ex_r.imm,                 e.imm);
    chk({e.tag, " alu_op"},  32'(id_ex_r.alu_op),         32'(e.alu));
    chk({e.tag, " wb_en"},   32'(id_ex_r.wb_en),          32'(e.wb_en));
    chk({e.tag, " is_load"}, 32'(id_ex_r.is_load),        32'(e.is_load));
    chk({e.tag, " is_store"},32'(id_ex_r.is_store),       32'(e.is_store));
    chk({e.tag, " ctrl"},    32'(id_ex_r.is_branch | id_ex_r.is_jump), 32'(e.is_ctrl));
    chk({e.tag, " illegal"}, 32'(id_ex_r.illegal),        32'(e.illegal));
  endtask

  task automatic drive(input logic [15:0] pc, input logic [31:0] inst,
                       input logic [4:0] rs1, rs2, rd, input logic dne);
    if_id.pc = pc; if_id.fetched_inst = inst;
    if_id.rs1 = rs1; if_id.rs2 = rs2; if_id.rd = rd; if_id.do_not_execute = dne;
  endtask

  // Clocks one cycle, compares the ID_EX output, returns at the next falling edge
  task automatic step();
    @(posedge clk);
    #1;
    check_out();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(16'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b1);
    redirect_valid = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0; rf1 = '0; rf2 = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //          tag      inst          rs1 rs2 rd  rf1           rf2           we wrd wdata         e_rs1         e_rs2         e_imm         alu      wb ld st ill
    tbl[0] = '{"addi",   32'hFFD08293, 1,  29, 5,  32'd10,       32'h55,       0, 0,  32'h0,        32'd10,       32'h55,       32'hFFFFFFFD, ALU_ADD, 1, 0, 0, 0};
    tbl[1] = '{"add_byp",32'h000180B3, 3,  0,  1,  32'h0,        32'h1234,     1, 3,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0,        ALU_ADD, 1, 0, 0, 0};
    tbl[2] = '{"sub",    32'h40C58533, 11, 12, 10, 32'd100,      32'd7,        0, 0,  32'h0,        32'd100,      32'd7,        32'h0,        ALU_SUB, 1, 0, 0, 0};
    tbl[3] = '{"sw",     32'hFE512E23, 2,  5,  28, 32'h1000,     32'hAB,       1, 5,  32'h77,       32'h1000,     32'h77,       32'hFFFFFFFC, ALU_ADD, 0, 0, 1, 0};
    tbl[4] = '{"srai",   32'h40525193, 4,  5,  3,  32'hF0000000, 32'h0,        0, 0,  32'h0,        32'hF0000000, 32'h0,        32'h405,      ALU_SRA, 1, 0, 0, 0};
    tbl[5] = '{"lw",     32'h00012303, 2,  0,  6,  32'h2000,     32'h99,       0, 0,  32'h0,        32'h2000,     32'h0,        32'h0,        ALU_ADD, 1, 1, 0, 0};
    tbl[6] = '{"lui",    32'h123453B7, 8,  3,  7,  32'h11,       32'h22,       0, 0,  32'h0,        32'h11,       32'h22,       32'h12345000, ALU_LUI, 1, 0, 0, 0};
    tbl[7] = '{"nop",    32'h00000013, 0,  0,  0,  32'h99,       32'h99,       0, 0,  32'h0,        32'h0,        32'h0,        32'h0,        ALU_ADD, 0, 0, 0, 0};
    tbl[8] = '{"illegal",32'h00000FFF, 0,  0,  31, 32'h5,        32'h6,        0, 0,  32'h0,        32'h0,        32'h0,        32'h0,        ALU_ADD, 0, 0, 0, 1};
    tbl[9] = '{"addi_b30",32'h40010493,2,  0,  9,  32'd5,        32'h0,        0, 0,  32'h0,        32'd5,        32'h0,        32'h400,      ALU_ADD, 1, 0, 0, 0};

    reset = 1'b1;
    drive(16'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b1);
    redirect_valid = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0; rf1 = '0; rf2 = '0;
    @(posedge clk);
    #1;
    chk("reset dne",          32'(id_ex_r.do_not_execute), 32'd1);
    chk("reset pc",           32'(id_ex_r.pc),             32'd0);
    chk("reset jip",          32'(jump_in_progress),       32'd0);
    chk("reset stall",        32'(stall_fetch),            32'd0);
    chk("reset bubble_count", 32'(bubble_count),           32'd0);
    do_reset();

    foreach (tbl[i]) begin
      drive(16'h0100 + 16'(i * 4), tbl[i].inst, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, 1'b0);
      rf1 = tbl[i].rf1; rf2 = tbl[i].rf2;
      wb_we = tbl[i].wb_we; wb_rd = tbl[i].wb_rd; wb_data = tbl[i].wb_data;
      sb_q.push_back(mk_dec(tbl[i].tag, 16'h0100 + 16'(i * 4), tbl[i].rd, tbl[i].e_rs1,
                            tbl[i].e_rs2, tbl[i].e_imm, tbl[i].e_alu, tbl[i].e_wb,
                            tbl[i].e_ld, tbl[i].e_st, 1'b0, tbl[i].e_ill));
      #1;
      chk({tbl[i].tag, " stall"}, 32'(stall_fetch), 32'd0);
      step();
    end
    wb_we = 1'b0;
    chk("table bubble_count", 32'(bubble_count), 32'd0);

    // Load-use: one stall cycle, one bubble, then the held ADD issues
    do_reset();
    drive(16'h0200, 32'h00012303, 5'd2, 5'd0, 5'd6, 1'b0); rf1 = 32'h2000; rf2 = 32'h0;
    sb_q.push_back(mk_dec("lu_lw", 16'h0200, 5'd6, 32'h2000, 32'h0, 32'h0, ALU_ADD, 1, 1, 0, 0, 0));
    step();
    drive(16'h0204, 32'h001303B3, 5'd6, 5'd1, 5'd7, 1'b0); rf1 = 32'h66; rf2 = 32'h11;
    sb_q.push_back(mk_bub("lu_bubble", 16'h0204));
    #1;
    chk("lu stall_on", 32'(stall_fetch), 32'd1);
    step();
    sb_q.push_back(mk_dec("lu_add", 16'h0204, 5'd7, 32'h66, 32'h11, 32'h0, ALU_ADD, 1, 0, 0, 0, 0));
    #1;
    chk("lu stall_off", 32'(stall_fetch), 32'd0);
    step();
    chk("lu bubble_count", 32'(bubble_count), 32'd1);

    // JAL: hold-off until redirect, then resume
    do_reset();
    drive(16'h0300, 32'h008000EF, 5'd0, 5'd8, 5'd1, 1'b0);
    sb_q.push_back(mk_dec("jal", 16'h0300, 5'd1, 32'h0, 32'h0, 32'h8, ALU_ADD, 1, 0, 0, 1, 0));
    step();
    chk("jal jip set", 32'(jump_in_progress), 32'd1);
    for (int k = 0; k < 2; k++) begin
      drive(16'h0304, 32'hFFD08293, 5'd1, 5'd29, 5'd5, 1'b0); rf1 = 32'd10; rf2 = 32'h55;
      sb_q.push_back(mk_bub("jal_wait", 16'h0304));
      #1;
      chk("jal_wait stall", 32'(stall_fetch), 32'd0);
      step();
      chk("jal_wait jip", 32'(jump_in_progress), 32'd1);
    end
    redirect_valid = 1'b1;
    sb_q.push_back(mk_bub("jal_redirect", 16'h0304));
    step();
    redirect_valid = 1'b0;
    chk("jal jip clear", 32'(jump_in_progress), 32'd0);
    sb_q.push_back(mk_dec("jal_resume", 16'h0304, 5'd5, 32'd10, 32'h55, 32'hFFFFFFFD, ALU_ADD, 1, 0, 0, 0, 0));
    step();
    chk("jal bubble_count", 32'(bubble_count), 32'd3);

    // Asynchronous reset mid-cycle while waiting on a jump
    drive(16'h0308, 32'h008000EF, 5'd0, 5'd8, 5'd1, 1'b0); rf1 = '0; rf2 = '0;
    sb_q.push_back(mk_dec("jal2", 16'h0308, 5'd1, 32'h0, 32'h0, 32'h8, ALU_ADD, 1, 0, 0, 1, 0));
    step();
    reset = 1'b1;
    #1;
    chk("async_rst dne",          32'(id_ex_r.do_not_execute), 32'd1);
    chk("async_rst jip",          32'(jump_in_progress),       32'd0);
    chk("async_rst bubble_count", 32'(bubble_count),           32'd0);
    chk("async_rst stall",        32'(stall_fetch),            32'd0);
    do_reset();

    // Redirect in the same cycle as a load-use hazard
    drive(16'h0400, 32'h00012303, 5'd2, 5'd0, 5'd6, 1'b0); rf1 = 32'h2000; rf2 = 32'h0;
    sb_q.push_back(mk_dec("rd_lw", 16'h0400, 5'd6, 32'h2000, 32'h0, 32'h0, ALU_ADD, 1, 1, 0, 0, 0));
    step();
    drive(16'h0404, 32'h001303B3, 5'd6, 5'd1, 5'd7, 1'b0); rf1 = 32'h66; rf2 = 32'h11;
    redirect_valid = 1'b1;
    sb_q.push_back(mk_bub("rd_flush", 16'h0404));
    #1;
    chk("rd stall", 32'(stall_fetch), 32'd0);
    step();
    redirect_valid = 1'b0;
    chk("rd jip", 32'(jump_in_progress), 32'd0);
    sb_q.push_back(mk_dec("rd_add", 16'h0404, 5'd7, 32'h66, 32'h11, 32'h0, ALU_ADD, 1, 0, 0, 0, 0));
    step();

    // BEQ x1,x2,-8 enters hold-off; redirect on the next cycle
    do_reset();
    drive(16'h0500, 32'hFE208CE3, 5'd1, 5'd2, 5'd25, 1'b0); rf1 = 32'd1; rf2 = 32'd2;
    sb_q.push_back(mk_dec("beq", 16'h0500, 5'd25, 32'd1, 32'd2, 32'hFFFFFFF8, ALU_SUB, 0, 0, 0, 1, 0));
    step();
    chk("beq jip", 32'(jump_in_progress), 32'd1);
    drive(16'h0504, 32'h0, 5'd0, 5'd0, 5'd0, 1'b1);
    redirect_valid = 1'b1;
    sb_q.push_back(mk_bub("beq_redirect", 16'h0504));
    step();
    redirect_valid = 1'b0;
    chk("beq jip clear", 32'(jump_in_progress), 32'd0);

    // Bubble counter saturation
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive(16'h0600, 32'h0, 5'd0, 5'd0, 5'd0, 1'b1);
      sb_q.push_back(mk_bub("idle", 16'h0600));
      step();
    end
    chk("bubble_count saturated", 32'(bubble_count), 32'd15);
    chk("scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
